// File: rtl/rename_pkg.sv
// Shared sizes and tag types for the register rename stage.
package rename_pkg;
  localparam int AR_SIZE   = 6;
  localparam int ARCH_SIZE = 5;
  localparam int PHYS_REGS = 64;
  localparam int ARCH_REGS = 32;

  typedef logic [AR_SIZE-1:0] ptag_t;
  typedef logic [AR_SIZE:0]   count_t;
endpackage

// File: rtl/register_rename_if.sv
// Decode-side, retire-side and writeback-side signals of the rename stage.
interface register_rename_if #(
  parameter int AR_SIZE   = rename_pkg::AR_SIZE,
  parameter int ARCH_SIZE = rename_pkg::ARCH_SIZE
);
  logic                   valid_in;
  logic [ARCH_SIZE-1:0]   rs1_arch_in;
  logic [ARCH_SIZE-1:0]   rs2_arch_in;
  logic [ARCH_SIZE-1:0]   rd_arch_in;
  logic                   rd_wr_in;
  logic                   stall_in;
  logic                   retire_valid_in;
  logic [AR_SIZE-1:0]     retire_old_pd_in;
  logic                   FU0_flag_in;
  logic                   FU1_flag_in;
  logic                   FU2_flag_in;
  logic [AR_SIZE-1:0]     reg_tag_from_FU0_in;
  logic [AR_SIZE-1:0]     reg_tag_from_FU1_in;
  logic [AR_SIZE-1:0]     reg_tag_from_FU2_in;
  logic                   valid_out;
  logic [AR_SIZE-1:0]     rs1_out;
  logic [AR_SIZE-1:0]     rs2_out;
  logic [AR_SIZE-1:0]     rd_out;
  logic [AR_SIZE-1:0]     old_rd_out;
  logic [(1<<AR_SIZE)-1:0] ready_vec_out;
  logic                   stall_out;
  logic [AR_SIZE:0]       free_count_out;

  modport master (
    output valid_in, rs1_arch_in, rs2_arch_in, rd_arch_in, rd_wr_in, stall_in,
           retire_valid_in, retire_old_pd_in, FU0_flag_in, FU1_flag_in, FU2_flag_in,
           reg_tag_from_FU0_in, reg_tag_from_FU1_in, reg_tag_from_FU2_in,
    input  valid_out, rs1_out, rs2_out, rd_out, old_rd_out, ready_vec_out,
           stall_out, free_count_out
  );

  modport slave (
    input  valid_in, rs1_arch_in, rs2_arch_in, rd_arch_in, rd_wr_in, stall_in,
           retire_valid_in, retire_old_pd_in, FU0_flag_in, FU1_flag_in, FU2_flag_in,
           reg_tag_from_FU0_in, reg_tag_from_FU1_in, reg_tag_from_FU2_in,
    output valid_out, rs1_out, rs2_out, rd_out, old_rd_out, ready_vec_out,
           stall_out, free_count_out
  );
endinterface

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical tags; pops come from allocation, pushes from retire.
module rename_free_list
  import rename_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   pop,
  input  logic   push,
  input  ptag_t  push_tag,
  output ptag_t  head_tag,
  output count_t count
);
  ptag_t mem [PHYS_REGS];
  ptag_t head;
  ptag_t tail;
  logic  push_ok;
  logic  pop_ok;

  // p0 is never freed, and a push into a full list is dropped rather than overwriting.
  assign push_ok  = push && (push_tag != '0) && (count != count_t'(PHYS_REGS));
  assign pop_ok   = pop && (count != '0);
  assign head_tag = mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        mem[i] <= (i < ARCH_REGS) ? ptag_t'(i + ARCH_REGS) : '0;
      end
      head  <= '0;
      tail  <= ptag_t'(ARCH_REGS);
      count <= count_t'(ARCH_REGS);
    end else begin
      if (push_ok) begin
        mem[tail] <= push_tag;
        tail      <= tail + ptag_t'(1);
      end
      if (pop_ok) begin
        head <= head + ptag_t'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + count_t'(1);
        2'b01:   count <= count - count_t'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/register_rename.sv
// Rename stage: RAT lookup, destination allocation from the free list, and ready table.
module register_rename #(
  parameter int AR_SIZE   = rename_pkg::AR_SIZE,
  parameter int ARCH_SIZE = rename_pkg::ARCH_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  register_rename_if.slave rn
);
  localparam int PHYS_REGS = 1 << AR_SIZE;
  localparam int ARCH_REGS = 1 << ARCH_SIZE;

  logic [AR_SIZE-1:0]   rat [ARCH_REGS];
  logic [PHYS_REGS-1:0] ready_q;
  logic [PHYS_REGS-1:0] ready_d;
  logic [AR_SIZE-1:0]   head_tag;
  logic [AR_SIZE:0]     free_count;
  logic                 stall;
  logic                 accept;
  logic                 alloc;

  assign stall         = rn.stall_in | (free_count == '0);
  assign accept        = rn.valid_in & ~stall;
  assign alloc         = accept & rn.rd_wr_in & (rn.rd_arch_in != '0);
  assign rn.stall_out      = stall;
  assign rn.free_count_out = free_count;
  assign rn.ready_vec_out  = ready_q;

  rename_free_list u_free_list (
    .clk      (clk),
    .rst      (rst),
    .pop      (alloc),
    .push     (rn.retire_valid_in),
    .push_tag (rn.retire_old_pd_in),
    .head_tag (head_tag),
    .count    (free_count)
  );

  // Allocation clear is applied after the writeback sets so it wins on a collision.
  always_comb begin
    ready_d = ready_q;
    if (rn.FU0_flag_in && rn.reg_tag_from_FU0_in != '0) ready_d[rn.reg_tag_from_FU0_in] = 1'b1;
    if (rn.FU1_flag_in && rn.reg_tag_from_FU1_in != '0) ready_d[rn.reg_tag_from_FU1_in] = 1'b1;
    if (rn.FU2_flag_in && rn.reg_tag_from_FU2_in != '0) ready_d[rn.reg_tag_from_FU2_in] = 1'b1;
    if (alloc) ready_d[head_tag] = 1'b0;
    ready_d[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat[i] <= AR_SIZE'(i);
      end
      ready_q       <= '1;
      rn.valid_out  <= 1'b0;
      rn.rs1_out    <= '0;
      rn.rs2_out    <= '0;
      rn.rd_out     <= '0;
      rn.old_rd_out <= '0;
    end else begin
      ready_q      <= ready_d;
      rn.valid_out <= accept;
      if (accept) begin
        rn.rs1_out    <= rat[rn.rs1_arch_in];
        rn.rs2_out    <= rat[rn.rs2_arch_in];
        rn.rd_out     <= alloc ? head_tag : '0;
        rn.old_rd_out <= alloc ? rat[rn.rd_arch_in] : '0;
      end
      if (alloc) begin
        rat[rn.rd_arch_in] <= head_tag;
      end
    end
  end
endmodule
